// File: rtl/tail_light_monitor_if.sv
// LED bus between the turn-signal FSM and its passive monitor.
// The FSM (master) drives the lamps; the monitor (slave) returns its decode and error status.
interface tail_light_monitor_if #(
  parameter int ERR_W = 8
);
  logic [5:0]       led;
  logic [1:0]       mode;
  logic             mode_valid;
  logic [1:0]       step;
  logic             seq_err;
  logic [ERR_W-1:0] err_count;

  modport master (
    output led,
    input  mode, mode_valid, step, seq_err, err_count
  );

  modport slave (
    input  led,
    output mode, mode_valid, step, seq_err, err_count
  );
endinterface

// File: rtl/tail_light_monitor.sv
// Passive checker for the tail-light bus: follows the lamp sequence and decodes the mode.
// It also flags any illegal sample and keeps a saturating error count. Every output is registered.
module tail_light_monitor #(
  parameter int IDLE_CYC = 2,
  parameter int ERR_W    = 8
) (
  input logic                 clk,
  input logic                 reset,
  tail_light_monitor_if.slave bus
);

  localparam logic [5:0] PAT_OFF = 6'b000000;
  localparam logic [5:0] PAT_L1  = 6'b001000;
  localparam logic [5:0] PAT_L2  = 6'b011000;
  localparam logic [5:0] PAT_L3  = 6'b111000;
  localparam logic [5:0] PAT_R1  = 6'b000100;
  localparam logic [5:0] PAT_R2  = 6'b000110;
  localparam logic [5:0] PAT_R3  = 6'b000111;
  localparam logic [5:0] PAT_HZ  = 6'b111111;

  localparam logic [3:0]       IDLE_LIM = 4'(IDLE_CYC);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [2:0] {
    S_OFF = 3'd0,
    S_L1  = 3'd1,
    S_L2  = 3'd2,
    S_L3  = 3'd3,
    S_R1  = 3'd4,
    S_R2  = 3'd5,
    S_R3  = 3'd6,
    S_HZ  = 3'd7
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [3:0]       off_cnt_r;
  logic [3:0]       off_cnt_nxt_s;
  logic             err_s;
  logic             done_s;
  logic [1:0]       done_mode_s;
  logic             idle_hit_s;
  logic [1:0]       mode_r;
  logic [1:0]       mode_nxt_s;
  logic             mode_valid_r;
  logic             mode_valid_nxt_s;
  logic [1:0]       step_r;
  logic [1:0]       step_nxt_s;
  logic             seq_err_r;
  logic [ERR_W-1:0] err_count_r;
  logic [ERR_W-1:0] err_count_nxt_s;

  // An illegal sample that is itself a sequence start is taken as a fresh start.
  function automatic state_t resync_state(input logic [5:0] pat);
    case (pat)
      PAT_L1:  resync_state = S_L1;
      PAT_R1:  resync_state = S_R1;
      PAT_HZ:  resync_state = S_HZ;
      default: resync_state = S_OFF;
    endcase
  endfunction

  function automatic logic [1:0] step_of(input state_t st);
    case (st)
      S_L1, S_R1, S_HZ: step_of = 2'd1;
      S_L2, S_R2:       step_of = 2'd2;
      S_L3, S_R3:       step_of = 2'd3;
      default:          step_of = 2'd0;
    endcase
  endfunction

  // State register and consecutive-off counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= S_OFF;
      off_cnt_r <= 4'd0;
    end else begin
      state_r   <= state_nxt_s;
      off_cnt_r <= off_cnt_nxt_s;
    end
  end

  // Next-state decode: compare the sample with the one pattern the current state allows.
  always_comb begin
    state_nxt_s = S_OFF;
    err_s       = 1'b0;
    done_s      = 1'b0;
    done_mode_s = 2'b00;
    case (state_r)
      S_OFF: begin
        case (bus.led)
          PAT_OFF: state_nxt_s = S_OFF;
          PAT_L1:  state_nxt_s = S_L1;
          PAT_R1:  state_nxt_s = S_R1;
          PAT_HZ:  state_nxt_s = S_HZ;
          default: err_s = 1'b1;
        endcase
      end
      S_L1: if (bus.led == PAT_L2) state_nxt_s = S_L2; else err_s = 1'b1;
      S_L2: if (bus.led == PAT_L3) state_nxt_s = S_L3; else err_s = 1'b1;
      S_R1: if (bus.led == PAT_R2) state_nxt_s = S_R2; else err_s = 1'b1;
      S_R2: if (bus.led == PAT_R3) state_nxt_s = S_R3; else err_s = 1'b1;
      S_L3, S_R3, S_HZ: begin
        if (bus.led == PAT_OFF) begin
          done_s = 1'b1;
          case (state_r)
            S_L3:    done_mode_s = 2'b01;
            S_R3:    done_mode_s = 2'b10;
            default: done_mode_s = 2'b11;
          endcase
        end else begin
          err_s = 1'b1;
        end
      end
      default: err_s = 1'b1;
    endcase
    if (err_s) begin
      state_nxt_s = resync_state(bus.led);
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // Output decode; errors outrank completions, which outrank the idle declaration.
  always_comb begin
    mode_nxt_s       = mode_r;
    mode_valid_nxt_s = mode_valid_r;
    if (bus.led == PAT_OFF) begin
      off_cnt_nxt_s = (off_cnt_r >= IDLE_LIM) ? IDLE_LIM : off_cnt_r + 4'd1;
    end else begin
      off_cnt_nxt_s = 4'd0;
    end
    idle_hit_s = (off_cnt_nxt_s == IDLE_LIM) && (off_cnt_r != IDLE_LIM);
    if (err_s) begin
      mode_nxt_s       = 2'b00;
      mode_valid_nxt_s = 1'b0;
    end else if (done_s) begin
      mode_nxt_s       = done_mode_s;
      mode_valid_nxt_s = 1'b1;
    end else if (idle_hit_s) begin
      mode_nxt_s       = 2'b00;
      mode_valid_nxt_s = 1'b1;
    end else begin
      mode_nxt_s       = mode_r;
      mode_valid_nxt_s = mode_valid_r;
    end
    step_nxt_s      = step_of(state_nxt_s);
    err_count_nxt_s = (err_s && (err_count_r != ERR_MAX)) ? err_count_r + {{(ERR_W-1){1'b0}}, 1'b1}
                                                          : err_count_r;
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_r       <= 2'b00;
      mode_valid_r <= 1'b0;
      step_r       <= 2'd0;
      seq_err_r    <= 1'b0;
      err_count_r  <= {ERR_W{1'b0}};
    end else begin
      mode_r       <= mode_nxt_s;
      mode_valid_r <= mode_valid_nxt_s;
      step_r       <= step_nxt_s;
      seq_err_r    <= err_s;
      err_count_r  <= err_count_nxt_s;
    end
  end

  assign bus.mode       = mode_r;
  assign bus.mode_valid = mode_valid_r;
  assign bus.step       = step_r;
  assign bus.seq_err    = seq_err_r;
  assign bus.err_count  = err_count_r;

endmodule
